// File: rtl/rf_scm_pkg.sv
// Shared types and helpers for the latch-based multi-port register file.
package rf_scm_pkg;

    // Widest write-port count the arbiter helpers are built for.
    localparam int MAX_PORTS  = 4;
    localparam int PORT_IDX_W = 2;

    // Number of byte lanes in a word of the given width.
    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

    // One-hot decode of a write-port index.
    function automatic logic [MAX_PORTS-1:0] port_onehot(input logic [PORT_IDX_W-1:0] idx);
        logic [MAX_PORTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Index of the highest requesting port; requests narrower than MAX_PORTS
    // are zero-extended by the caller. Highest index wins a byte-lane conflict.
    function automatic logic [PORT_IDX_W-1:0] highest_port(input logic [MAX_PORTS-1:0] req);
        logic [PORT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (req[i]) idx = PORT_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cluster_clock_gating.sv
// Glitch-free integrated clock gate: enable captured while clk is low.
module cluster_clock_gating (
    input  logic clk,
    input  logic en,
    input  logic test_en,
    output logic gated_clk
);

    logic en_latched;

    // Transparent-low enable latch feeding the AND gate.
    // NOTE: this latch is intentional (always_latch); capturing the enable only while clk is low keeps gated_clk free of glitches.
    always_latch begin
        if (!clk) en_latched <= en | test_en;
    end

    assign gated_clk = clk & en_latched;

endmodule

// File: rtl/rf_scm_write_arbiter.sv
// Per (word, byte) gate enable and winning write port for the current cycle.
module rf_scm_write_arbiter
    import rf_scm_pkg::*;
#(
    parameter  int ADDR_WIDTH = 5,
    parameter  int N_WRITE    = 2,
    parameter  int BE_WIDTH   = 4,
    localparam int NUM_WORDS  = 2 ** ADDR_WIDTH,
    localparam int NUM_LANES  = NUM_WORDS * BE_WIDTH
) (
    input  logic                                  rst_n,
    input  logic [N_WRITE-1:0]                    write_enable,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]    write_addr,
    input  logic [N_WRITE-1:0][BE_WIDTH-1:0]      write_be,
    output logic [NUM_LANES-1:0]                  lane_en,
    output logic [NUM_LANES-1:0][PORT_IDX_W-1:0]  lane_winner
);

    // Collect the requesting ports per lane; reset suppresses every gate.
    always_comb begin
        logic [MAX_PORTS-1:0] req;
        lane_en     = '0;
        lane_winner = '0;
        req         = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                req = '0;
                for (int p = 0; p < N_WRITE; p++) begin
                    req[p] = write_enable[p] && (write_addr[p] == ADDR_WIDTH'(w)) && write_be[p][b];
                end
                lane_en[w*BE_WIDTH+b]     = rst_n && (|req);
                lane_winner[w*BE_WIDTH+b] = highest_port(req);
            end
        end
    end

endmodule

// File: rtl/register_file_nw_multi_port_read_be.sv
// Latch-based SCM register file: N write ports with byte enables,
// N read ports with registered addresses, write-first, highest port wins.
module register_file_nw_multi_port_read_be
    import rf_scm_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_READ     = 2,
    parameter int N_WRITE    = 2,
    parameter int BE_WIDTH   = byte_lanes(DATA_WIDTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                test_en_i,
    input  logic [N_READ-1:0]                   ReadEnable,
    input  logic [N_READ-1:0][ADDR_WIDTH-1:0]   ReadAddr,
    output logic [N_READ-1:0][DATA_WIDTH-1:0]   ReadData,
    input  logic [N_WRITE-1:0]                  WriteEnable,
    input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]  WriteAddr,
    input  logic [N_WRITE-1:0][BE_WIDTH-1:0]    WriteBE,
    input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]  WriteData
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int NUM_LANES = NUM_WORDS * BE_WIDTH;

    logic                                 clk_global;
    logic [NUM_LANES-1:0]                 lane_en;
    logic [NUM_LANES-1:0]                 lane_clk;
    logic [NUM_LANES-1:0][PORT_IDX_W-1:0] lane_winner;
    logic [NUM_LANES-1:0][PORT_IDX_W-1:0] winner_q;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0]   wdata_q;
    logic [NUM_LANES-1:0][7:0]            lane_data;
    logic [DATA_WIDTH-1:0]                mem [NUM_WORDS];
    logic [N_READ-1:0][ADDR_WIDTH-1:0]    raddr_q;

    // Global gate: the sample registers only clock when a write is requested.
    cluster_clock_gating u_cg_global (
        .clk       (clk),
        .en        (|WriteEnable),
        .test_en   (test_en_i),
        .gated_clk (clk_global)
    );

    rf_scm_write_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_WRITE    (N_WRITE),
        .BE_WIDTH   (BE_WIDTH)
    ) u_arbiter (
        .rst_n        (rst_n),
        .write_enable (WriteEnable),
        .write_addr   (WriteAddr),
        .write_be     (WriteBE),
        .lane_en      (lane_en),
        .lane_winner  (lane_winner)
    );

    // Read address registers: load on ReadEnable, hold otherwise.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        for (int r = 0; r < N_READ; r++) begin
            if (!rst_n)             raddr_q[r] <= '0;
            else if (ReadEnable[r]) raddr_q[r] <= ReadAddr[r];
        end
    end

    // Sample write data of requesting ports and the per-lane winner.
    always_ff @(posedge clk_global) begin
        if (!rst_n) begin
            wdata_q  <= '0;
            winner_q <= '0;
        end else begin
            for (int p = 0; p < N_WRITE; p++) begin
                if (WriteEnable[p]) wdata_q[p] <= WriteData[p];
            end
            winner_q <= lane_winner;
        end
    end

    // Route the winning port's byte onto each lane's latch input.
    always_comb begin
        logic [N_WRITE-1:0] sel;
        lane_data = '0;
        sel       = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            sel = N_WRITE'(port_onehot(winner_q[l]));
            for (int p = 0; p < N_WRITE; p++) begin
                if (sel[p]) lane_data[l] = wdata_q[p][(l % BE_WIDTH)*8 +: 8];
            end
        end
    end

    // One gate per (word, byte); opens during the high phase after the request.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane_cg
        cluster_clock_gating u_cg_lane (
            .clk       (clk),
            .en        (lane_en[l]),
            .test_en   (1'b0),
            .gated_clk (lane_clk[l])
        );
    end

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q;

        // Storage latches, transparent while the lane's gated clock is high.
        // NOTE: storage is deliberately not reset; a word is undefined until first written.
        always_latch begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (lane_clk[w*BE_WIDTH+b]) word_q[b*8 +: 8] <= lane_data[w*BE_WIDTH+b];
            end
        end

        assign mem[w] = word_q;
    end

    // Combinational read through the registered addresses.
    always_comb begin
        ReadData = '0;
        for (int r = 0; r < N_READ; r++) begin
            ReadData[r] = mem[raddr_q[r]];
        end
    end

endmodule

// File: tb/tb_register_file_nw_multi_port_read_be.sv
// Directed and scoreboard tests for register_file_nw_multi_port_read_be.
module tb_register_file_nw_multi_port_read_be;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int N_READ     = 2;
    localparam int N_WRITE    = 2;
    localparam int BE_WIDTH   = 4;
    localparam int NUM_WORDS  = 32;

    logic                                clk = 1'b0;
    logic                                rst_n;
    logic                                test_en_i;
    logic [N_READ-1:0]                   read_enable;
    logic [N_READ-1:0][ADDR_WIDTH-1:0]   read_addr;
    logic [N_READ-1:0][DATA_WIDTH-1:0]   read_data;
    logic [N_WRITE-1:0]                  write_enable;
    logic [N_WRITE-1:0][ADDR_WIDTH-1:0]  write_addr;
    logic [N_WRITE-1:0][BE_WIDTH-1:0]    write_be;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0]  write_data;

    int checks = 0;
    int errors = 0;

    logic [DATA_WIDTH-1:0] model   [NUM_WORDS];
    logic [ADDR_WIDTH-1:0] raddr_m [N_READ];

    register_file_nw_multi_port_read_be dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .test_en_i   (test_en_i),
        .ReadEnable  (read_enable),
        .ReadAddr    (read_addr),
        .ReadData    (read_data),
        .WriteEnable (write_enable),
        .WriteAddr   (write_addr),
        .WriteBE     (write_be),
        .WriteData   (write_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_enable  = '0;
        write_enable = '0;
        write_addr   = '0;
        write_be     = '0;
        write_data   = '0;
    endtask

    task automatic put_write(input int port, input logic [ADDR_WIDTH-1:0] addr,
                             input logic [BE_WIDTH-1:0] be, input logic [DATA_WIDTH-1:0] data);
        write_enable[port] = 1'b1;
        write_addr[port]   = addr;
        write_be[port]     = be;
        write_data[port]   = data;
    endtask

    task automatic put_read(input int port, input logic [ADDR_WIDTH-1:0] addr);
        read_enable[port] = 1'b1;
        read_addr[port]   = addr;
    endtask

    function automatic logic [ADDR_WIDTH-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return ADDR_WIDTH'($urandom_range(0, 31));
        return ADDR_WIDTH'($urandom_range(0, 7));
    endfunction

    task automatic test_reset();
        checks++;
        if (dut.raddr_q !== '0) begin
            errors++;
            $display("FAIL reset_raddr: got %h expected 0", dut.raddr_q);
        end
        checks++;
        if (dut.wdata_q !== '0) begin
            errors++;
            $display("FAIL reset_wdata: got %h expected 0", dut.wdata_q);
        end
    endtask

    task automatic test_basic_write_read();
        put_write(0, 5'd3, 4'hF, 32'hDEADBEEF);
        tick();
        idle();
        put_read(1, 5'd3);
        tick();
        idle();
        checks++;
        if (read_data[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_rd1_addr3: got %h expected deadbeef", read_data[1]);
        end
    endtask

    task automatic test_byte_enable();
        put_write(0, 5'd5, 4'hF, 32'h11223344);
        tick();
        idle();
        put_write(1, 5'd5, 4'h6, 32'hAABBCCDD);
        tick();
        idle();
        put_read(0, 5'd5);
        tick();
        idle();
        checks++;
        if (read_data[0] !== 32'h11BBCC44) begin
            errors++;
            $display("FAIL byte_enable_merge: got %h expected 11bbcc44", read_data[0]);
        end
    endtask

    task automatic test_conflict();
        put_write(0, 5'd7, 4'hF, 32'h01010101);
        put_write(1, 5'd7, 4'hF, 32'h02020202);
        put_read(1, 5'd7);
        tick();
        idle();
        checks++;
        if (read_data[1] !== 32'h02020202) begin
            errors++;
            $display("FAIL conflict_full: got %h expected 02020202", read_data[1]);
        end
        put_write(0, 5'd7, 4'h3, 32'h01010101);
        put_write(1, 5'd7, 4'hC, 32'h02020202);
        tick();
        idle();
        checks++;
        if (read_data[1] !== 32'h02020101) begin
            errors++;
            $display("FAIL conflict_disjoint: got %h expected 02020101", read_data[1]);
        end
        put_write(0, 5'd7, 4'hF, 32'hAAAAAAAA);
        put_write(1, 5'd7, 4'h1, 32'h000000BB);
        tick();
        idle();
        checks++;
        if (read_data[1] !== 32'hAAAAAABB) begin
            errors++;
            $display("FAIL conflict_partial: got %h expected aaaaaabb", read_data[1]);
        end
        // Lowest and highest words written by different ports in one cycle.
        put_write(0, 5'd0, 4'hF, 32'h00C0FFEE);
        put_write(1, 5'd31, 4'hF, 32'h31313131);
        put_read(0, 5'd31);
        put_read(1, 5'd0);
        tick();
        idle();
        checks++;
        if (read_data[0] !== 32'h31313131) begin
            errors++;
            $display("FAIL edge_addr31: got %h expected 31313131", read_data[0]);
        end
        checks++;
        if (read_data[1] !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL edge_addr0: got %h expected 00c0ffee", read_data[1]);
        end
    endtask

    task automatic test_write_first();
        put_write(0, 5'd9, 4'hF, 32'hCAFEF00D);
        put_read(0, 5'd9);
        tick();
        idle();
        checks++;
        if (read_data[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL write_first: got %h expected cafef00d", read_data[0]);
        end
        put_write(1, 5'd9, 4'hF, 32'h00000000);
        tick();
        idle();
        checks++;
        if (read_data[0] !== 32'h00000000) begin
            errors++;
            $display("FAIL held_read_follows: got %h expected 00000000", read_data[0]);
        end
    endtask

    task automatic test_zero_be_and_gating();
        put_write(0, 5'd2, 4'hF, 32'h55555555);
        put_read(1, 5'd2);
        tick();
        idle();
        checks++;
        if (read_data[1] !== 32'h55555555) begin
            errors++;
            $display("FAIL preload_addr2: got %h expected 55555555", read_data[1]);
        end
        put_write(0, 5'd2, 4'h0, 32'hFFFFFFFF);
        tick();
        checks++;
        if (read_data[1] !== 32'h55555555) begin
            errors++;
            $display("FAIL zero_be_no_update: got %h expected 55555555", read_data[1]);
        end
        checks++;
        if (dut.clk_global !== 1'b1) begin
            errors++;
            $display("FAIL zero_be_global_gate: got %b expected 1", dut.clk_global);
        end
        checks++;
        if (dut.lane_clk !== '0) begin
            errors++;
            $display("FAIL zero_be_lane_gates: got %h expected 0", dut.lane_clk);
        end
        idle();
        tick();
        checks++;
        if (dut.clk_global !== 1'b0) begin
            errors++;
            $display("FAIL idle_global_gate: got %b expected 0", dut.clk_global);
        end
        checks++;
        if (dut.lane_clk !== '0) begin
            errors++;
            $display("FAIL idle_lane_gates: got %h expected 0", dut.lane_clk);
        end
    endtask

    task automatic test_back_to_back();
        put_write(0, 5'd12, 4'hF, 32'h11111111);
        put_read(0, 5'd12);
        tick();
        idle();
        checks++;
        if (read_data[0] !== 32'h11111111) begin
            errors++;
            $display("FAIL b2b_first: got %h expected 11111111", read_data[0]);
        end
        put_write(1, 5'd12, 4'hF, 32'h22222222);
        tick();
        idle();
        checks++;
        if (read_data[0] !== 32'h22222222) begin
            errors++;
            $display("FAIL b2b_second: got %h expected 22222222", read_data[0]);
        end
        put_write(0, 5'd12, 4'h3, 32'h33333333);
        tick();
        idle();
        checks++;
        if (read_data[0] !== 32'h22223333) begin
            errors++;
            $display("FAIL b2b_third: got %h expected 22223333", read_data[0]);
        end
    endtask

    task automatic test_reset_mid_write();
        put_write(1, 5'd4, 4'hF, 32'h44444444);
        tick();
        idle();
        put_write(0, 5'd6, 4'hF, 32'h66666666);
        tick();
        idle();
        rst_n = 1'b0;
        put_write(0, 5'd4, 4'hF, 32'hBADBAD00);
        put_read(0, 5'd9);
        tick();
        rst_n = 1'b1;
        idle();
        checks++;
        if (dut.raddr_q !== '0) begin
            errors++;
            $display("FAIL midreset_raddr: got %h expected 0", dut.raddr_q);
        end
        checks++;
        if (dut.wdata_q !== '0) begin
            errors++;
            $display("FAIL midreset_wdata: got %h expected 0", dut.wdata_q);
        end
        checks++;
        if (read_data[0] !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL midreset_word0: got %h expected 00c0ffee", read_data[0]);
        end
        put_read(0, 5'd4);
        put_read(1, 5'd6);
        tick();
        idle();
        checks++;
        if (read_data[0] !== 32'h44444444) begin
            errors++;
            $display("FAIL midreset_discard: got %h expected 44444444", read_data[0]);
        end
        checks++;
        if (read_data[1] !== 32'h66666666) begin
            errors++;
            $display("FAIL midreset_prior_write: got %h expected 66666666", read_data[1]);
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < NUM_WORDS; w++) begin
            model[w] = $urandom;
            put_write(w % 2, ADDR_WIDTH'(w), 4'hF, model[w]);
            tick();
            idle();
        end
        put_read(0, 5'd0);
        put_read(1, 5'd1);
        raddr_m[0] = 5'd0;
        raddr_m[1] = 5'd1;
        tick();
        idle();
        for (int i = 0; i < 10000; i++) begin
            for (int p = 0; p < N_WRITE; p++) begin
                if ($urandom_range(0, 1) == 1)
                    put_write(p, rnd_addr(), BE_WIDTH'($urandom_range(0, 15)), $urandom);
            end
            for (int r = 0; r < N_READ; r++) begin
                if ($urandom_range(0, 2) == 0) put_read(r, rnd_addr());
            end
            // Ascending port order lets the higher port overwrite shared bytes.
            for (int p = 0; p < N_WRITE; p++) begin
                if (write_enable[p]) begin
                    for (int b = 0; b < BE_WIDTH; b++) begin
                        if (write_be[p][b]) model[write_addr[p]][b*8 +: 8] = write_data[p][b*8 +: 8];
                    end
                end
            end
            for (int r = 0; r < N_READ; r++) begin
                if (read_enable[r]) raddr_m[r] = read_addr[r];
            end
            tick();
            idle();
            for (int r = 0; r < N_READ; r++) begin
                checks++;
                if (read_data[r] !== model[raddr_m[r]]) begin
                    errors++;
                    $display("FAIL random_cycle%0d_port%0d addr %0d: got %h expected %h",
                             i, r, raddr_m[r], read_data[r], model[raddr_m[r]]);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        test_en_i = 1'b1;
        read_addr = '0;
        idle();
        tick();
        tick();
        rst_n     = 1'b1;
        test_en_i = 1'b0;
        test_reset();
        test_basic_write_read();
        test_byte_enable();
        test_conflict();
        test_write_first();
        test_zero_be_and_gating();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
